// File: rtl/matrix_stack_pkg.sv
// rtl/matrix_stack_pkg.sv - shared types and constants for the matrix stack
package matrix_stack_pkg;

  localparam int ROW_W  = 128;
  localparam int ELEM_W = 32;

  // Q16.16 one; element 0 of a row sits in the top 32 bits
  localparam logic [ELEM_W-1:0] Q_ONE = 32'h0001_0000;

  localparam logic [ROW_W-1:0] ID_ROW0 = {Q_ONE, 96'h0};
  localparam logic [ROW_W-1:0] ID_ROW1 = {32'h0, Q_ONE, 64'h0};
  localparam logic [ROW_W-1:0] ID_ROW2 = {64'h0, Q_ONE, 32'h0};
  localparam logic [ROW_W-1:0] ID_ROW3 = {96'h0, Q_ONE};

  typedef enum logic [1:0] {
    OP_LOAD_IDENTITY = 2'b00,
    OP_PUSH          = 2'b01,
    OP_POP           = 2'b10,
    OP_LOAD          = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PUSH_WR,
    ST_POP_RD,
    ST_POP_WR
  } state_e;

  typedef logic [3:0][ROW_W-1:0] matrix_t;

  function automatic matrix_t identity_matrix();
    return {ID_ROW3, ID_ROW2, ID_ROW1, ID_ROW0};
  endfunction

endpackage

// File: rtl/matrix_stack_if.sv
// rtl/matrix_stack_if.sv - command, write-back, peek and status signals of the matrix stack
interface matrix_stack_if;
  import matrix_stack_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             cmd_mode;
  logic [ROW_W-1:0] load_row_0;
  logic [ROW_W-1:0] load_row_1;
  logic [ROW_W-1:0] load_row_2;
  logic [ROW_W-1:0] load_row_3;
  logic             matrix_write_en;
  logic             matrix_mode_in;
  logic [ROW_W-1:0] matrix_write_in_0;
  logic [ROW_W-1:0] matrix_write_in_1;
  logic [ROW_W-1:0] matrix_write_in_2;
  logic [ROW_W-1:0] matrix_write_in_3;
  logic             peek_mode;
  logic [ROW_W-1:0] matrix_peek_0;
  logic [ROW_W-1:0] matrix_peek_1;
  logic [ROW_W-1:0] matrix_peek_2;
  logic [ROW_W-1:0] matrix_peek_3;
  logic [3:0]       depth_mv;
  logic [3:0]       depth_proj;
  logic             err_overflow;
  logic             err_underflow;
  logic             err_collision;
  logic             err_clear;

  modport master (
    output cmd_valid, cmd_op, cmd_mode,
    output load_row_0, load_row_1, load_row_2, load_row_3,
    output matrix_write_en, matrix_mode_in,
    output matrix_write_in_0, matrix_write_in_1, matrix_write_in_2, matrix_write_in_3,
    output peek_mode, err_clear,
    input  cmd_ready, matrix_peek_0, matrix_peek_1, matrix_peek_2, matrix_peek_3,
    input  depth_mv, depth_proj, err_overflow, err_underflow, err_collision
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_mode,
    input  load_row_0, load_row_1, load_row_2, load_row_3,
    input  matrix_write_en, matrix_mode_in,
    input  matrix_write_in_0, matrix_write_in_1, matrix_write_in_2, matrix_write_in_3,
    input  peek_mode, err_clear,
    output cmd_ready, matrix_peek_0, matrix_peek_1, matrix_peek_2, matrix_peek_3,
    output depth_mv, depth_proj, err_overflow, err_underflow, err_collision
  );

endinterface

// File: rtl/matrix_stack_ram.sv
// rtl/matrix_stack_ram.sv - single-port synchronous row RAM holding saved matrices
module matrix_stack_ram
  import matrix_stack_pkg::*;
#(
  parameter int WORDS  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ROW_W-1:0]  wdata,
  output logic [ROW_W-1:0]  rdata
);

  logic [ROW_W-1:0] mem_q [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/matrix_stack.sv
// rtl/matrix_stack.sv - modelview/projection matrix stacks with push/pop through a row RAM
module matrix_stack
  import matrix_stack_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  matrix_stack_if.slave  bus
);

  localparam int WORDS  = 2 * DEPTH * 4;
  localparam int ADDR_W = $clog2(WORDS);

  state_e           state_q, state_d;
  logic [1:0]       row_q, row_d;
  logic             op_mode_q, op_mode_d;
  matrix_t [1:0]    cur_q, cur_d;
  logic [1:0][3:0]  depth_q, depth_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, col_q, col_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [ROW_W-1:0]  ram_wdata;
  logic [ROW_W-1:0]  ram_rdata;
  logic [3:0]        pop_idx;

  function automatic logic [ADDR_W-1:0] word_addr(input logic m, input logic [3:0] idx,
                                                  input logic [1:0] r);
    return ADDR_W'((int'(m) * DEPTH + int'(idx)) * 4 + int'(r));
  endfunction

  assign bus.cmd_ready     = (state_q == ST_IDLE) && !bus.matrix_write_en;
  assign bus.matrix_peek_0 = cur_q[bus.peek_mode][0];
  assign bus.matrix_peek_1 = cur_q[bus.peek_mode][1];
  assign bus.matrix_peek_2 = cur_q[bus.peek_mode][2];
  assign bus.matrix_peek_3 = cur_q[bus.peek_mode][3];
  assign bus.depth_mv      = depth_q[0];
  assign bus.depth_proj    = depth_q[1];
  assign bus.err_overflow  = ovf_q;
  assign bus.err_underflow = unf_q;
  assign bus.err_collision = col_q;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    op_mode_d = op_mode_q;
    cur_d     = cur_q;
    depth_d   = depth_q;
    ovf_d     = ovf_q & ~bus.err_clear;
    unf_d     = unf_q & ~bus.err_clear;
    col_d     = col_q & ~bus.err_clear;
    ram_we    = 1'b0;
    pop_idx   = depth_q[op_mode_q] - 4'd1;
    ram_addr  = word_addr(op_mode_q, pop_idx, row_q);
    ram_wdata = cur_q[op_mode_q][row_q];

    unique case (state_q)
      ST_IDLE: begin
        if (bus.matrix_write_en) begin
          cur_d[bus.matrix_mode_in] = {bus.matrix_write_in_3, bus.matrix_write_in_2,
                                       bus.matrix_write_in_1, bus.matrix_write_in_0};
        end else if (bus.cmd_valid) begin
          op_mode_d = bus.cmd_mode;
          row_d     = 2'd0;
          unique case (cmd_op_e'(bus.cmd_op))
            OP_LOAD_IDENTITY: cur_d[bus.cmd_mode] = identity_matrix();
            OP_LOAD: cur_d[bus.cmd_mode] = {bus.load_row_3, bus.load_row_2,
                                            bus.load_row_1, bus.load_row_0};
            OP_PUSH: begin
              if (depth_q[bus.cmd_mode] == 4'(DEPTH)) ovf_d = 1'b1;
              else                                    state_d = ST_PUSH_WR;
            end
            OP_POP: begin
              if (depth_q[bus.cmd_mode] == 4'd0) unf_d = 1'b1;
              else                               state_d = ST_POP_RD;
            end
          endcase
        end
      end
      ST_PUSH_WR: begin
        ram_we   = 1'b1;
        ram_addr = word_addr(op_mode_q, depth_q[op_mode_q], row_q);
        row_d    = row_q + 2'd1;
        if (row_q == 2'd3) begin
          depth_d[op_mode_q] = depth_q[op_mode_q] + 4'd1;
          state_d            = ST_IDLE;
        end
      end
      ST_POP_RD: begin
        row_d   = row_q + 2'd1;
        state_d = ST_POP_WR;
      end
      ST_POP_WR: begin
        // reads run one row ahead of the write-back into cur
        cur_d[op_mode_q][row_q - 2'd1] = ram_rdata;
        row_d = row_q + 2'd1;
        if (row_q == 2'd0) begin
          depth_d[op_mode_q] = depth_q[op_mode_q] - 4'd1;
          state_d            = ST_IDLE;
        end
      end
    endcase

    if ((state_q != ST_IDLE) && bus.matrix_write_en) begin
      col_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      row_q     <= 2'd0;
      op_mode_q <= 1'b0;
      cur_q     <= {identity_matrix(), identity_matrix()};
      depth_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      col_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      op_mode_q <= op_mode_d;
      cur_q     <= cur_d;
      depth_q   <= depth_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      col_q     <= col_d;
    end
  end

  matrix_stack_ram #(
    .WORDS  (WORDS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_matrix_stack.sv
// tb/tb_matrix_stack.sv - self-checking bench for matrix_stack against a stack-of-matrices model
module tb_matrix_stack;

  localparam int DEPTH = 8;
  typedef logic [3:0][127:0] mat_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  matrix_stack_if bus();

  matrix_stack #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  bit   check_en = 1'b0;

  mat_t m_cur [2];
  mat_t m_stk0 [$];
  mat_t m_stk1 [$];
  int   m_busy;
  int   m_pend_op;
  int   m_pend_mode;
  bit   m_ovf, m_unf, m_col;

  mat_t a_mat, b_mat, c_mat;
  int   cnt;

  function automatic mat_t ident();
    mat_t m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r][127-32*c -: 32] = (r == c) ? 32'h0001_0000 : 32'h0;
    return m;
  endfunction

  function automatic logic [127:0] rnd_row();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic int depth_of(input int m);
    return (m == 0) ? m_stk0.size() : m_stk1.size();
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    m_cur[0] = ident();
    m_cur[1] = ident();
    m_stk0.delete();
    m_stk1.delete();
    m_busy = 0;
    m_ovf = 0; m_unf = 0; m_col = 0;
  endtask

  // One rising edge of the model, using the inputs presented before that edge
  task automatic model_step();
    bit ev_o, ev_u, ev_c;
    int m;
    ev_o = 0; ev_u = 0; ev_c = 0;
    m = int'(bus.cmd_mode);
    if (m_busy > 0) begin
      if (bus.matrix_write_en) ev_c = 1;
      m_busy--;
      if (m_busy == 0) begin
        if (m_pend_op == 1) begin
          if (m_pend_mode == 0) m_stk0.push_back(m_cur[0]);
          else                  m_stk1.push_back(m_cur[1]);
        end else begin
          if (m_pend_mode == 0) m_cur[0] = m_stk0.pop_back();
          else                  m_cur[1] = m_stk1.pop_back();
        end
      end
    end else if (bus.matrix_write_en) begin
      m_cur[bus.matrix_mode_in] = {bus.matrix_write_in_3, bus.matrix_write_in_2,
                                   bus.matrix_write_in_1, bus.matrix_write_in_0};
    end else if (bus.cmd_valid) begin
      case (bus.cmd_op)
        2'b00: m_cur[m] = ident();
        2'b11: m_cur[m] = {bus.load_row_3, bus.load_row_2, bus.load_row_1, bus.load_row_0};
        2'b01: if (depth_of(m) == DEPTH) ev_o = 1;
               else begin m_busy = 4; m_pend_op = 1; m_pend_mode = m; end
        default: if (depth_of(m) == 0) ev_u = 1;
                 else begin m_busy = 5; m_pend_op = 2; m_pend_mode = m; end
      endcase
    end
    m_ovf = (m_ovf && !bus.err_clear) || ev_o;
    m_unf = (m_unf && !bus.err_clear) || ev_u;
    m_col = (m_col && !bus.err_clear) || ev_c;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("cmd_ready", 128'(bus.cmd_ready), 128'(m_busy == 0 && !bus.matrix_write_en));
      chk("depth_mv", 128'(bus.depth_mv), 128'(depth_of(0)));
      chk("depth_proj", 128'(bus.depth_proj), 128'(depth_of(1)));
      chk("err_overflow", 128'(bus.err_overflow), 128'(m_ovf));
      chk("err_underflow", 128'(bus.err_underflow), 128'(m_unf));
      chk("err_collision", 128'(bus.err_collision), 128'(m_col));
      if (m_busy == 0) begin
        chk("peek_0", bus.matrix_peek_0, m_cur[bus.peek_mode][0]);
        chk("peek_1", bus.matrix_peek_1, m_cur[bus.peek_mode][1]);
        chk("peek_2", bus.matrix_peek_2, m_cur[bus.peek_mode][2]);
        chk("peek_3", bus.matrix_peek_3, m_cur[bus.peek_mode][3]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    if (!reset_n) model_reset();
    else          model_step();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic issue(input logic [1:0] op, input logic mode);
    bus.cmd_op    = op;
    bus.cmd_mode  = mode;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic set_load(input mat_t m);
    bus.load_row_0 = m[0]; bus.load_row_1 = m[1];
    bus.load_row_2 = m[2]; bus.load_row_3 = m[3];
  endtask

  task automatic set_write(input mat_t m);
    bus.matrix_write_in_0 = m[0]; bus.matrix_write_in_1 = m[1];
    bus.matrix_write_in_2 = m[2]; bus.matrix_write_in_3 = m[3];
  endtask

  task automatic chk_peek(input string name, input mat_t m);
    chk(name, bus.matrix_peek_0, m[0]);
    chk(name, bus.matrix_peek_1, m[1]);
    chk(name, bus.matrix_peek_2, m[2]);
    chk(name, bus.matrix_peek_3, m[3]);
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_mode = 1'b0;
    bus.matrix_write_en = 1'b0; bus.matrix_mode_in = 1'b0;
    bus.peek_mode = 1'b0; bus.err_clear = 1'b0;
    for (int r = 0; r < 4; r++) begin
      a_mat[r] = rnd_row();
      b_mat[r] = rnd_row();
      c_mat[r] = rnd_row();
    end
    set_load(a_mat);
    set_write(b_mat);
    #2;
    do_reset();
    check_en = 1'b1;

    // reset values, identity rows as literals
    #1;
    chk("rst_peek0", bus.matrix_peek_0, 128'h0001_0000_0000_0000_0000_0000_0000_0000);
    chk("rst_peek3", bus.matrix_peek_3, 128'h0000_0000_0000_0000_0000_0000_0001_0000);
    chk("rst_depth_mv", 128'(bus.depth_mv), 128'd0);
    chk("rst_depth_proj", 128'(bus.depth_proj), 128'd0);

    // load, push, identity, pop restores the loaded matrix
    set_load(a_mat);
    issue(2'b11, 1'b0);
    issue(2'b01, 1'b0);
    wait_ready(cnt);
    chk("push_busy_cycles", 128'(cnt), 128'd4);
    chk("push_depth", 128'(bus.depth_mv), 128'd1);
    issue(2'b00, 1'b0);
    chk("loadid_peek1", bus.matrix_peek_1, 128'h0000_0000_0001_0000_0000_0000_0000_0000);
    issue(2'b10, 1'b0);
    wait_ready(cnt);
    chk("pop_busy_cycles", 128'(cnt), 128'd5);
    chk_peek("pop_restore", a_mat);
    chk("pop_depth", 128'(bus.depth_mv), 128'd0);

    // write strobe beats a same-cycle command, which is then taken next cycle
    set_write(b_mat);
    bus.matrix_write_en = 1'b1; bus.matrix_mode_in = 1'b1;
    bus.cmd_op = 2'b01; bus.cmd_mode = 1'b1; bus.cmd_valid = 1'b1;
    #1;
    chk("we_blocks_ready", 128'(bus.cmd_ready), 128'd0);
    step();
    bus.matrix_write_en = 1'b0;
    bus.peek_mode = 1'b1;
    #1;
    chk_peek("we_proj", b_mat);
    chk("we_no_push", 128'(bus.depth_proj), 128'd0);
    step();
    bus.cmd_valid = 1'b0;
    chk("push_taken", 128'(bus.cmd_ready), 128'd0);
    wait_ready(cnt);
    chk("push_taken_depth", 128'(bus.depth_proj), 128'd1);

    // write strobe while busy is dropped and flagged
    bus.peek_mode = 1'b0;
    issue(2'b01, 1'b0);
    set_write(c_mat);
    bus.matrix_write_en = 1'b1; bus.matrix_mode_in = 1'b0;
    step();
    bus.matrix_write_en = 1'b0;
    chk("collision_set", 128'(bus.err_collision), 128'd1);
    bus.err_clear = 1'b1;
    step();
    bus.err_clear = 1'b0;
    chk("collision_clr", 128'(bus.err_collision), 128'd0);
    wait_ready(cnt);
    chk_peek("collision_dropped", a_mat);

    // overflow on the ninth push, underflow on an empty pop
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (i == DEPTH) chk("no_ovf_yet", 128'(bus.err_overflow), 128'd0);
      issue(2'b01, 1'b1);
      wait_ready(cnt);
    end
    chk("full_depth", 128'(bus.depth_proj), 128'd8);
    chk("overflow", 128'(bus.err_overflow), 128'd1);
    issue(2'b10, 1'b0);
    chk("underflow", 128'(bus.err_underflow), 128'd1);
    chk("underflow_depth", 128'(bus.depth_mv), 128'd0);

    // reset during the second cycle of a pop
    do_reset();
    set_load(a_mat);
    issue(2'b11, 1'b0);
    issue(2'b01, 1'b0);
    wait_ready(cnt);
    issue(2'b10, 1'b0);
    step();
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("abort_ready", 128'(bus.cmd_ready), 128'd1);
    chk("abort_depth", 128'(bus.depth_mv), 128'd0);
    chk("abort_peek0", bus.matrix_peek_0, 128'h0001_0000_0000_0000_0000_0000_0000_0000);
    step();
    reset_n = 1'b1;
    issue(2'b10, 1'b0);
    chk("abort_underflow", 128'(bus.err_underflow), 128'd1);

    // randomized traffic, push-heavy then pop-heavy
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 9);
      bus.cmd_valid = ($urandom_range(0, 2) != 0);
      if (i < 1500) bus.cmd_op = (r < 5) ? 2'b01 : (r < 7) ? 2'b10 : (r < 9) ? 2'b11 : 2'b00;
      else          bus.cmd_op = (r < 5) ? 2'b10 : (r < 7) ? 2'b01 : (r < 9) ? 2'b11 : 2'b00;
      bus.cmd_mode = 1'($urandom_range(0, 1));
      bus.load_row_0 = rnd_row(); bus.load_row_1 = rnd_row();
      bus.load_row_2 = rnd_row(); bus.load_row_3 = rnd_row();
      bus.matrix_write_en = ($urandom_range(0, 9) == 0);
      bus.matrix_mode_in = 1'($urandom_range(0, 1));
      bus.matrix_write_in_0 = rnd_row(); bus.matrix_write_in_1 = rnd_row();
      bus.matrix_write_in_2 = rnd_row(); bus.matrix_write_in_3 = rnd_row();
      bus.err_clear = ($urandom_range(0, 15) == 0);
      bus.peek_mode = 1'($urandom_range(0, 1));
      step();
    end
    bus.cmd_valid = 1'b0; bus.matrix_write_en = 1'b0; bus.err_clear = 1'b0;
    for (int i = 0; i < 8; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
